// File: rtl/multi_sos_dist_calc_if.sv
// Handshake and data bundle for the multi-channel speed-of-sound
// distance calculator: sample strobe, mic samples, impulse control, results.
interface multi_sos_dist_calc_if #(
    parameter int NUM_CH = 2
);
    logic                   step_in;
    logic                   trigger_in;
    logic                   abort_in;
    logic [NUM_CH*16-1:0]   mic_in;
    logic                   impulse_done_in;
    logic                   impulse_req_out;
    logic [NUM_CH*12-1:0]   delay_out;
    logic [NUM_CH-1:0]      delay_valid_out;
    logic                   busy_out;
    logic                   done_out;
    logic                   timeout_out;

    modport master (
        output step_in,
        output trigger_in,
        output abort_in,
        output mic_in,
        output impulse_done_in,
        input  impulse_req_out,
        input  delay_out,
        input  delay_valid_out,
        input  busy_out,
        input  done_out,
        input  timeout_out
    );

    modport slave (
        input  step_in,
        input  trigger_in,
        input  abort_in,
        input  mic_in,
        input  impulse_done_in,
        output impulse_req_out,
        output delay_out,
        output delay_valid_out,
        output busy_out,
        output done_out,
        output timeout_out
    );
endinterface

// File: rtl/multi_sos_dist_calc.sv
// Multi-channel echo delay estimator: pings, windowed energy onset
// detection per mic, and multi-ping agreement before a delay is confirmed.
module multi_sos_dist_calc #(
    parameter int NUM_CH         = 2,
    parameter int WINDOW_SIZE    = 16,
    parameter int MAX_DELAY      = 512,
    parameter int RATIO_SHIFT    = 1,
    parameter int CONFIRM_COUNT  = 3,
    parameter int MAX_PINGS      = 16,
    parameter int HOLDOFF_CYCLES = 98_300_000
) (
    input logic                  clk_in,
    input logic                  rst_in,
    multi_sos_dist_calc_if.slave bus
);
    localparam int SW = 16 + $clog2(WINDOW_SIZE) + 1;
    localparam int TW = SW + RATIO_SHIFT;
    localparam int CW = $clog2(MAX_DELAY + 1);
    localparam int WW = $clog2(WINDOW_SIZE + 1);
    localparam int AW = $clog2(CONFIRM_COUNT + 1);
    localparam int PW = $clog2(MAX_PINGS + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, START, AWAIT, ANALYZE, HOLDOFF, DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          sample_cnt;
    logic [WW-1:0]          win_cnt;
    logic [PW-1:0]          ping_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [SW-1:0]          sum_q   [NUM_CH];
    logic [SW-1:0]          prev_q  [NUM_CH];
    logic [SW-1:0]          pprev_q [NUM_CH];
    logic [NUM_CH-1:0]      locked_q;
    logic [CW-1:0]          cand_q  [NUM_CH];
    logic [CW-1:0]          last_q  [NUM_CH];
    logic [AW-1:0]          agree_q [NUM_CH];
    logic [NUM_CH*12-1:0]   delay_q;
    logic [NUM_CH-1:0]      valid_q;
    logic                   req_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   timeout_q;

    logic [CW-1:0]          cnt_inc;
    logic                   win_end;
    logic                   ping_end;
    logic [16:0]            mag       [NUM_CH];
    logic [SW-1:0]          acc       [NUM_CH];
    logic [CW-1:0]          cand_nxt  [NUM_CH];
    logic [AW-1:0]          agree_nxt [NUM_CH];
    logic [NUM_CH-1:0]      hit;
    logic [NUM_CH-1:0]      lock_nxt;
    logic [NUM_CH-1:0]      confirm;
    logic [NUM_CH-1:0]      valid_nxt;

    assign bus.impulse_req_out = req_q;
    assign bus.delay_out       = delay_q;
    assign bus.delay_valid_out = valid_q;
    assign bus.busy_out        = busy_q;
    assign bus.done_out        = done_q;
    assign bus.timeout_out     = timeout_q;

    // Per-step energy accumulation, onset test and end-of-ping agreement.
    always_comb begin
        cnt_inc   = sample_cnt + CW'(1);
        win_end   = (win_cnt == WW'(WINDOW_SIZE - 1));
        hit       = '0;
        lock_nxt  = '0;
        confirm   = '0;
        valid_nxt = valid_q;
        for (int k = 0; k < NUM_CH; k++) begin
            // 17-bit negate keeps -32768 as +32768
            if (bus.mic_in[k*16+15])
                mag[k] = 17'd0 - {1'b1, bus.mic_in[k*16 +: 16]};
            else
                mag[k] = {1'b0, bus.mic_in[k*16 +: 16]};
            acc[k] = sum_q[k] + SW'(mag[k]);
            hit[k] = win_end && !locked_q[k]
                && (TW'(acc[k]) > (TW'(prev_q[k]) << RATIO_SHIFT))
                && (TW'(acc[k]) > (TW'(pprev_q[k]) << RATIO_SHIFT));
            lock_nxt[k] = locked_q[k] | hit[k];
            cand_nxt[k] = hit[k] ? cnt_inc : cand_q[k];
            if (!lock_nxt[k])
                agree_nxt[k] = '0;
            else if (cand_nxt[k] != last_q[k])
                agree_nxt[k] = AW'(1);
            else if (agree_q[k] == AW'(CONFIRM_COUNT))
                agree_nxt[k] = agree_q[k];
            else
                agree_nxt[k] = agree_q[k] + AW'(1);
            confirm[k] = (agree_nxt[k] == AW'(CONFIRM_COUNT))
                && !valid_q[k];
            valid_nxt[k] = valid_q[k] | confirm[k];
        end
        ping_end = bus.step_in
            && ((&lock_nxt) || (cnt_inc == CW'(MAX_DELAY)));
    end

    // Measurement sequencer with all state and outputs registered.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            sample_cnt <= '0;
            win_cnt    <= '0;
            ping_cnt   <= '0;
            hold_cnt   <= '0;
            locked_q   <= '0;
            delay_q    <= '0;
            valid_q    <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                sum_q[k]   <= '0;
                prev_q[k]  <= '0;
                pprev_q[k] <= '0;
                cand_q[k]  <= '0;
                last_q[k]  <= '0;
                agree_q[k] <= '0;
            end
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            if (bus.abort_in) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.trigger_in) begin
                            valid_q   <= '0;
                            timeout_q <= 1'b0;
                            ping_cnt  <= '0;
                            busy_q    <= 1'b1;
                            state     <= START;
                            for (int k = 0; k < NUM_CH; k++)
                                agree_q[k] <= '0;
                        end
                    end
                    START: begin
                        req_q    <= 1'b1;
                        ping_cnt <= ping_cnt + PW'(1);
                        state    <= AWAIT;
                    end
                    AWAIT: begin
                        if (bus.impulse_done_in) begin
                            sample_cnt <= '0;
                            win_cnt    <= '0;
                            locked_q   <= '0;
                            state      <= ANALYZE;
                            // all-ones history blocks onset in
                            // the first two windows
                            for (int k = 0; k < NUM_CH; k++) begin
                                sum_q[k]   <= '0;
                                prev_q[k]  <= '1;
                                pprev_q[k] <= '1;
                            end
                        end
                    end
                    ANALYZE: begin
                        if (bus.step_in) begin
                            sample_cnt <= cnt_inc;
                            win_cnt    <= win_end ? '0
                                        : win_cnt + WW'(1);
                            locked_q   <= lock_nxt;
                            for (int k = 0; k < NUM_CH; k++) begin
                                cand_q[k] <= cand_nxt[k];
                                if (win_end) begin
                                    pprev_q[k] <= prev_q[k];
                                    prev_q[k]  <= acc[k];
                                    sum_q[k]   <= '0;
                                end else begin
                                    sum_q[k] <= acc[k];
                                end
                            end
                            if (ping_end) begin
                                for (int k = 0; k < NUM_CH; k++) begin
                                    agree_q[k] <= agree_nxt[k];
                                    if (lock_nxt[k])
                                        last_q[k] <= cand_nxt[k];
                                    if (confirm[k]) begin
                                        delay_q[k*12 +: 12]
                                            <= 12'(cand_nxt[k]);
                                        valid_q[k] <= 1'b1;
                                    end
                                end
                                if (&valid_nxt) begin
                                    state <= DONE;
                                end else if (ping_cnt
                                        == PW'(MAX_PINGS)) begin
                                    timeout_q <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    hold_cnt <= '0;
                                    state    <= HOLDOFF;
                                end
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (hold_cnt == HW'(HOLDOFF_CYCLES - 1))
                            state <= START;
                        else
                            hold_cnt <= hold_cnt + HW'(1);
                    end
                    DONE: begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multi_sos_dist_calc.sv
// Bench for multi_sos_dist_calc: emulated echo source and impulse
// generator, directed scenario table plus randomized model-checked pings.
module tb_multi_sos_dist_calc;
    localparam int NCH = 2;
    localparam int WS  = 16;
    localparam int MD  = 512;
    localparam int RS  = 1;
    localparam int CC  = 3;
    localparam int MP  = 16;
    localparam int HO  = 40;

    typedef struct {
        int       on0a;
        int       on0b;
        int       on1;
        int       amp0;
        int       amp1;
        bit       lead;
        bit       mid;
        int       d0;
        int       d1;
        bit [1:0] v;
        bit       to;
        int       pings;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    multi_sos_dist_calc_if #(.NUM_CH(NCH)) bus();

    multi_sos_dist_calc #(
        .NUM_CH(NCH), .WINDOW_SIZE(WS), .MAX_DELAY(MD),
        .RATIO_SHIFT(RS), .CONFIRM_COUNT(CC),
        .MAX_PINGS(MP), .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    vec_t cfg;
    int   cfg_base = 0;
    int   imp_cnt  = 0;
    int   done_cnt = 0;
    int   emu_n    = 0;
    int   held[NCH];
    int   n_vec    = 0;
    int   n_err    = 0;

    // Echo level seen by mic ch on step n of ping p (steps numbered from 1).
    function automatic int echo(vec_t c, int ch, int p, int n);
        int on;
        int amp;
        if (ch == 0) begin
            on  = (p % 2 == 1) ? c.on0a : c.on0b;
            amp = c.amp0;
        end else begin
            on  = c.on1;
            amp = c.amp1;
        end
        if (on != 0 && n >= on) return amp;
        if (ch == 0 && c.lead && n <= 32) return -32768;
        return 0;
    endfunction

    // Reference: first window end whose energy beats twice both of the
    // two preceding full windows; 0 when none within MD samples.
    function automatic int ref_cand(vec_t c, int ch, int p);
        longint win[$];
        longint e;
        int s;
        int w;
        e = 0;
        for (int n = 1; n <= MD; n++) begin
            s = echo(c, ch, p, n);
            e += (s < 0) ? -s : s;
            if (n % WS == 0) begin
                win.push_back(e);
                e = 0;
                w = win.size();
                if (w >= 3 && win[w-1] > (win[w-2] << RS)
                        && win[w-1] > (win[w-3] << RS))
                    return n;
            end
        end
        return 0;
    endfunction

    // Reference: streak of identical per-ping candidates confirms a delay.
    task automatic ref_meas(input vec_t vi, output vec_t vo);
        int last[NCH];
        int run[NCH];
        int c;
        vo = vi;
        vo.v = '0;
        vo.to = 1'b0;
        vo.pings = MP;
        for (int ch = 0; ch < NCH; ch++) begin
            last[ch] = 0;
            run[ch] = 0;
        end
        for (int p = 1; p <= MP; p++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                c = ref_cand(vi, ch, p);
                if (c != 0) begin
                    run[ch] = (c == last[ch])
                        ? ((run[ch] < CC) ? run[ch] + 1 : CC) : 1;
                    last[ch] = c;
                end else begin
                    run[ch] = 0;
                end
                if (run[ch] >= CC && !vo.v[ch]) begin
                    vo.v[ch] = 1'b1;
                    if (ch == 0) vo.d0 = c;
                    else vo.d1 = c;
                end
            end
            if (&vo.v) begin
                vo.pings = p;
                break;
            end
            if (p == MP) vo.to = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Impulse generator and echo source; counts impulses and done pulses.
    initial begin
        int req_cd;
        bit active;
        logic [NCH*16-1:0] m;
        req_cd = 0;
        active = 1'b0;
        m = '0;
        bus.step_in = 1'b0;
        bus.impulse_done_in = 1'b0;
        bus.mic_in = '0;
        forever begin
            @(negedge clk_in);
            bus.step_in = 1'b0;
            bus.impulse_done_in = 1'b0;
            if (bus.impulse_req_out === 1'b1) begin
                imp_cnt++;
                req_cd = 3;
                active = 1'b0;
                emu_n = 0;
            end else if (req_cd > 0) begin
                req_cd--;
                if (req_cd == 0) begin
                    bus.impulse_done_in = 1'b1;
                    active = 1'b1;
                end
            end else if (active && $urandom_range(7) != 0) begin
                emu_n++;
                bus.step_in = 1'b1;
                for (int ch = 0; ch < NCH; ch++)
                    m[ch*16 +: 16] =
                        16'(echo(cfg, ch, imp_cnt - cfg_base, emu_n));
                bus.mic_in = m;
            end
            if (bus.done_out === 1'b1) done_cnt++;
        end
    end

    task automatic pulse_trigger();
        @(negedge clk_in);
        bus.trigger_in = 1'b1;
        @(negedge clk_in);
        bus.trigger_in = 1'b0;
    endtask

    task automatic wait_steps(input int steps, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk_in);
            if (imp_cnt - cfg_base >= 1 && emu_n >= steps) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_meas(input vec_t v, input string tag);
        int bi;
        int bd;
        bit seen;
        bit ok;
        cfg = v;
        cfg_base = imp_cnt;
        bi = imp_cnt;
        bd = done_cnt;
        pulse_trigger();
        chk({tag, " busy"}, bus.busy_out, 1);
        if (v.mid) begin
            wait_steps(20, ok);
            chk({tag, " reach mid"}, ok, 1);
            pulse_trigger();
        end
        seen = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk_in);
            if (bus.done_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " done seen"}, seen, 1);
        if (v.v[0]) held[0] = v.d0;
        if (v.v[1]) held[1] = v.d1;
        chk({tag, " delay0"}, bus.delay_out[11:0], held[0]);
        chk({tag, " delay1"}, bus.delay_out[23:12], held[1]);
        chk({tag, " valid"}, bus.delay_valid_out, v.v);
        chk({tag, " timeout"}, bus.timeout_out, v.to);
        chk({tag, " busy end"}, bus.busy_out, 0);
        repeat (5) @(negedge clk_in);
        chk({tag, " impulses"}, imp_cnt - bi, v.pings);
        chk({tag, " dones"}, done_cnt - bd, 1);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        vec_t ev;
        int bi;
        int bd;
        bit ok;
        int a;
        tbl[0] = '{96, 96, 160, 4000, 4000, 0, 1,
                   96, 160, 2'b11, 0, 3};
        tbl[1] = '{96, 96, 0, 4000, 0, 0, 0,
                   96, 0, 2'b01, 1, 16};
        tbl[2] = '{96, 112, 160, 4000, 4000, 0, 0,
                   0, 160, 2'b10, 1, 16};
        tbl[3] = '{96, 96, 0, -32768, 0, 1, 0,
                   96, 0, 2'b01, 1, 16};
        tbl[4] = '{200, 200, 40, -5000, 3000, 0, 0,
                   208, 48, 2'b11, 0, 3};
        tbl[5] = '{500, 500, 512, 7000, -7000, 0, 0,
                   512, 512, 2'b11, 0, 3};
        cfg = tbl[0];
        held[0] = 0;
        held[1] = 0;
        bus.trigger_in = 1'b0;
        bus.abort_in = 1'b0;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst busy", bus.busy_out, 0);
        chk("rst done", bus.done_out, 0);
        chk("rst req", bus.impulse_req_out, 0);
        chk("rst valid", bus.delay_valid_out, 0);
        chk("rst timeout", bus.timeout_out, 0);
        chk("rst delay", bus.delay_out, 0);
        rst_in = 1'b1;

        for (int i = 0; i < 6; i++)
            run_meas(tbl[i], $sformatf("T%0d", i));

        // abort while waiting between pings
        cfg = tbl[1];
        cfg_base = imp_cnt;
        bi = imp_cnt;
        bd = done_cnt;
        pulse_trigger();
        wait_steps(MD, ok);
        chk("abort reach holdoff", ok, 1);
        repeat (5) @(negedge clk_in);
        chk("abort busy before", bus.busy_out, 1);
        bus.abort_in = 1'b1;
        @(negedge clk_in);
        bus.abort_in = 1'b0;
        chk("abort busy", bus.busy_out, 0);
        repeat (200) @(negedge clk_in);
        chk("abort impulses", imp_cnt - bi, 1);
        chk("abort dones", done_cnt - bd, 0);
        chk("abort delay", bus.delay_out,
            {12'(held[1]), 12'(held[0])});
        chk("abort valid", bus.delay_valid_out, 0);

        // reset in the middle of a ping
        cfg_base = imp_cnt;
        bi = imp_cnt;
        bd = done_cnt;
        pulse_trigger();
        wait_steps(50, ok);
        chk("reset reach analyze", ok, 1);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        chk("reset busy", bus.busy_out, 0);
        chk("reset delay", bus.delay_out, 0);
        chk("reset valid", bus.delay_valid_out, 0);
        repeat (200) @(negedge clk_in);
        chk("reset impulses", imp_cnt - bi, 1);
        chk("reset dones", done_cnt - bd, 0);
        held[0] = 0;
        held[1] = 0;

        for (int r = 0; r < 6; r++) begin
            rv = tbl[0];
            rv.mid = 1'b0;
            rv.lead = 1'b0;
            rv.on0a = $urandom_range(MD, 33);
            rv.on0b = rv.on0a;
            rv.on1 = $urandom_range(MD, 33);
            a = $urandom_range(32767, 500);
            if ($urandom_range(1) == 1) a = -a;
            if ($urandom_range(4) == 0) a = -32768;
            rv.amp0 = a;
            a = $urandom_range(32767, 500);
            if ($urandom_range(1) == 1) a = -a;
            rv.amp1 = a;
            ref_meas(rv, ev);
            run_meas(ev, $sformatf("R%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
